// File: rtl/ps2_kbd_rx.sv
// ============================================================================
// ps2_kbd_rx : PS/2 keyboard receiver with set-2 E0/F0 prefix decoding
// Revision   : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module ps2_kbd_rx #(
  parameter int unsigned FILTER_LEN  = 8,
  parameter int unsigned TIMEOUT_CYC = 2000
) (
  input  logic        clk_i,
  input  logic        rst,
  input  logic        ps2_clk_i,
  input  logic        ps2_data_i,
  output logic [31:0] data_o,
  output logic        we_o,
  output logic        frame_err_o
);

  localparam int unsigned FW = $clog2(FILTER_LEN + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

  localparam logic [7:0] C_BYTE_EXT = 8'hE0;
  localparam logic [7:0] C_BYTE_BRK = 8'hF0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } state_t;

  // input conditioning
  logic          clk_meta_q, clk_sync_q;
  logic          data_meta_q, data_sync_q;
  logic          filt_q, filt_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          fall_q, fall_d;

  // frame state
  state_t        state_q, state_d;
  logic [2:0]    bcnt_q, bcnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          ext_q, ext_d;
  logic          brk_q, brk_d;
  logic [10:0]   data_q, data_d;
  logic          we_q, we_d;
  logic          err_q, err_d;
  logic          timeout_w;
  logic          frame_ok_w;

  always_ff @(posedge clk_i) begin
    if (!rst) begin
      clk_meta_q  <= 1'b1;
      clk_sync_q  <= 1'b1;
      data_meta_q <= 1'b1;
      data_sync_q <= 1'b1;
      filt_q      <= 1'b1;
      fcnt_q      <= '0;
      fall_q      <= 1'b0;
    end else begin
      clk_meta_q  <= ps2_clk_i;
      clk_sync_q  <= clk_meta_q;
      data_meta_q <= ps2_data_i;
      data_sync_q <= data_meta_q;
      filt_q      <= filt_d;
      fcnt_q      <= fcnt_d;
      fall_q      <= fall_d;
    end
  end

  // Level flips only after FILTER_LEN consecutive samples disagree with it.
  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    if (clk_sync_q != filt_q) begin
      if (fcnt_q == FW'(FILTER_LEN - 1)) begin
        filt_d = clk_sync_q;
      end else begin
        fcnt_d = fcnt_q + FW'(1);
      end
    end
    fall_d = filt_q & ~filt_d;
  end

  always_ff @(posedge clk_i) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      bcnt_q  <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tcnt_q  <= '0;
      ext_q   <= 1'b0;
      brk_q   <= 1'b0;
      data_q  <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tcnt_q  <= tcnt_d;
      ext_q   <= ext_d;
      brk_q   <= brk_d;
      data_q  <= data_d;
      we_q    <= we_d;
      err_q   <= err_d;
    end
  end

  assign timeout_w  = (state_q != ST_IDLE) && (tcnt_q == TW'(TIMEOUT_CYC - 1));
  assign frame_ok_w = data_sync_q && ((^shift_q) ^ par_q);

  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    shift_d = shift_q;
    par_d   = par_q;
    tcnt_d  = '0;
    ext_d   = ext_q;
    brk_d   = brk_q;
    data_d  = data_q;
    we_d    = 1'b0;
    err_d   = 1'b0;

    if (state_q != ST_IDLE) begin
      tcnt_d = fall_q ? '0 : tcnt_q + TW'(1);
    end

    // A timeout wins over a coincident fall so the fall cannot restart a frame.
    if (timeout_w) begin
      state_d = ST_IDLE;
      err_d   = 1'b1;
      ext_d   = 1'b0;
      brk_d   = 1'b0;
    end else if (fall_q) begin
      case (state_q)
        ST_IDLE: begin
          if (!data_sync_q) begin
            state_d = ST_DATA;
            bcnt_d  = '0;
          end
        end
        ST_DATA: begin
          shift_d = {data_sync_q, shift_q[7:1]};
          bcnt_d  = bcnt_q + 3'd1;
          if (bcnt_q == 3'd7) begin
            state_d = ST_PARITY;
          end
        end
        ST_PARITY: begin
          par_d   = data_sync_q;
          state_d = ST_STOP;
        end
        ST_STOP: begin
          state_d = ST_IDLE;
          if (!frame_ok_w) begin
            err_d = 1'b1;
            ext_d = 1'b0;
            brk_d = 1'b0;
          end else if (shift_q == C_BYTE_EXT) begin
            ext_d = 1'b1;
          end else if (shift_q == C_BYTE_BRK) begin
            brk_d = 1'b1;
          end else begin
            data_d = {1'b1, ext_q, brk_q, shift_q};
            we_d   = 1'b1;
            ext_d  = 1'b0;
            brk_d  = 1'b0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign data_o      = {21'b0, data_q};
  assign we_o        = we_q;
  assign frame_err_o = err_q;

endmodule

`default_nettype wire

// File: tb/tb_ps2_kbd_rx.sv
// ============================================================================
// tb_ps2_kbd_rx : scoreboard bench for ps2_kbd_rx (directed + random frames)
// Revision      : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_ps2_kbd_rx;

  logic        clk_i      = 1'b0;
  logic        rst        = 1'b0;
  logic        ps2_clk_i  = 1'b1;
  logic        ps2_data_i = 1'b1;
  logic [31:0] data_o;
  logic        we_o;
  logic        frame_err_o;

  always #50 clk_i = ~clk_i;

  ps2_kbd_rx #(
    .FILTER_LEN (8),
    .TIMEOUT_CYC(2000)
  ) dut (
    .clk_i      (clk_i),
    .rst        (rst),
    .ps2_clk_i  (ps2_clk_i),
    .ps2_data_i (ps2_data_i),
    .data_o     (data_o),
    .we_o       (we_o),
    .frame_err_o(frame_err_o)
  );

  typedef struct packed {
    logic        is_err;
    logic        is_to;
    logic [31:0] word;
  } exp_t;

  exp_t    exp_q[$];
  int      n_checks = 0;
  int      n_fail   = 0;
  bit      m_ext    = 1'b0;
  bit      m_brk    = 1'b0;
  realtime last_fall = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_i);
    #2;
  endtask

  task automatic push_exp(input bit is_err, input bit is_to, input logic [31:0] word);
    exp_t e;
    e.is_err = is_err;
    e.is_to  = is_to;
    e.word   = word;
    exp_q.push_back(e);
  endtask

  // Keyboard-level model: what the host should report for one received byte.
  task automatic model_byte(input logic [7:0] b, input bit bad);
    if (bad) begin
      push_exp(1'b1, 1'b0, 32'h0);
      m_ext = 1'b0;
      m_brk = 1'b0;
    end else if (b == 8'hE0) begin
      m_ext = 1'b1;
    end else if (b == 8'hF0) begin
      m_brk = 1'b1;
    end else begin
      push_exp(1'b0, 1'b0, 32'h400 + (m_ext ? 32'h200 : 32'h0) + (m_brk ? 32'h100 : 32'h0) + 32'(b));
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endtask

  // Device-to-host frame: data changes while clock is high, host samples on the fall.
  task automatic send_frame(input logic [7:0] b, input bit bad, input int half,
                            input int nbits, input bit glitch);
    logic [10:0] bits;
    bits[0]   = 1'b0;
    bits[8:1] = b;
    bits[9]   = ~(^b) ^ bad;
    bits[10]  = 1'b1;
    for (int i = 0; i < nbits; i++) begin
      ps2_data_i = bits[i];
      cyc(half / 2);
      if (glitch && i == 3) begin
        ps2_clk_i = 1'b0;
        cyc(3);
        ps2_clk_i = 1'b1;
      end
      cyc(half - half / 2);
      ps2_clk_i = 1'b0;
      last_fall = $realtime;
      cyc(half);
      ps2_clk_i = 1'b1;
    end
    ps2_data_i = 1'b1;
    cyc(half);
  endtask

  task automatic key(input logic [7:0] b, input bit bad, input int half);
    model_byte(b, bad);
    send_frame(b, bad, half, 11, 1'b0);
  endtask

  // Monitor: every strobe or error pulse must match the head of the scoreboard.
  initial begin
    exp_t    e;
    realtime dt;
    forever begin
      @(negedge clk_i);
      if (we_o || frame_err_o) begin
        check("we_err_exclusive", 32'(we_o & frame_err_o), 32'h0);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_event: got we=%0b err=%0b data=%h expected none", we_o, frame_err_o, data_o);
        end else begin
          e = exp_q.pop_front();
          check("event_kind_err", 32'(frame_err_o), 32'(e.is_err));
          if (!e.is_err) check("data_o", data_o, e.word);
          if (e.is_to) begin
            dt = $realtime - last_fall;
            check("timeout_delay_199_205us", 32'(dt >= 199000.0 && dt <= 205000.0), 32'h1);
          end
        end
      end
    end
  end

  initial begin
    #20ms;
    $display("FAIL watchdog: got no completion expected finish before 20ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] b;
    cyc(5);
    check("reset_data_o", data_o, 32'h0);
    check("reset_we_o", 32'(we_o), 32'h0);
    check("reset_frame_err_o", 32'(frame_err_o), 32'h0);
    rst = 1'b1;
    cyc(20);

    // 12.5 kHz PS/2 clock: 40 us per half period
    key(8'h1C, 1'b0, 400);
    cyc(50);
    check("hold_data_o_1C", data_o, 32'h0000041C);

    key(8'hF0, 1'b0, 30);
    key(8'h1C, 1'b0, 30);
    key(8'hE0, 1'b0, 30);
    key(8'h75, 1'b0, 30);
    key(8'hE0, 1'b0, 30);
    key(8'hF0, 1'b0, 30);
    key(8'h75, 1'b0, 30);

    key(8'hF0, 1'b0, 30);
    key(8'h1C, 1'b1, 30);
    key(8'h29, 1'b0, 30);

    // partial frame after an E0 prefix, then bus idle long enough to time out
    key(8'hE0, 1'b0, 30);
    push_exp(1'b1, 1'b1, 32'h0);
    m_ext = 1'b0;
    m_brk = 1'b0;
    send_frame(8'h5A, 1'b0, 30, 6, 1'b0);
    cyc(2500);
    key(8'h1C, 1'b0, 30);

    // short clock glitches, idle and mid-frame
    ps2_clk_i = 1'b0;
    cyc(3);
    ps2_clk_i = 1'b1;
    cyc(50);
    model_byte(8'h1C, 1'b0);
    send_frame(8'h1C, 1'b0, 30, 11, 1'b1);

    // reset in the middle of a frame that follows a break prefix
    key(8'hF0, 1'b0, 30);
    send_frame(8'h1C, 1'b0, 30, 5, 1'b0);
    rst = 1'b0;
    cyc(2);
    check("midreset_data_o", data_o, 32'h0);
    check("midreset_we_o", 32'(we_o), 32'h0);
    check("midreset_frame_err_o", 32'(frame_err_o), 32'h0);
    rst = 1'b1;
    m_ext = 1'b0;
    m_brk = 1'b0;
    cyc(20);
    key(8'h1C, 1'b0, 30);

    // randomized key sequences
    for (int i = 0; i < 20; i++) begin
      int half;
      half = int'($urandom_range(15, 40));
      if ($urandom_range(0, 3) == 0) key(8'hE0, 1'b0, half);
      if ($urandom_range(0, 3) == 0) key(8'hF0, 1'b0, half);
      b = 8'($urandom_range(0, 255));
      key(b, ($urandom_range(0, 7) == 0), half);
    end

    cyc(100);
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ps2_kbd_rx.md
Name: ps2_kbd_rx

Overview:
- Receives PS/2 keyboard frames (device-to-host) on the raw ps2_clk/ps2_data pins and decodes scancode set 2 prefixes.
- Produces a 32-bit key word plus a one-cycle write strobe.
- Sits directly upstream of the keyboard register and drives its second data input and second write enable.
- Runs in the 10 MHz system clock domain; the PS/2 lines are asynchronous.

Parameters:
- FILTER_LEN, 8, number of consecutive identical synchronized samples required to accept a new ps2_clk level.
- TIMEOUT_CYC, 2000, system cycles without a filtered falling edge before a partial frame is abandoned (200 us at 10 MHz).

Ports:
- clk_i  in  1  system clock, 10 MHz.
- rst  in  1  synchronous, active-low reset; clock clk_i.
- ps2_clk_i  in  1  raw PS/2 clock pin, asynchronous.
- ps2_data_i  in  1  raw PS/2 data pin, asynchronous.
- data_o  out  32  key word: [7:0] scancode, [8] break (F0 seen), [9] extended (E0 seen), [10] new-key flag (always 1 when written), [31:11] zero.
- we_o  out  1  one-cycle write strobe qualifying data_o.
- frame_err_o  out  1  one-cycle pulse on parity error, bad stop bit or timeout.

Behaviour:
- Reset (rst=0 at posedge clk_i):
  - data_o=0, we_o=0, frame_err_o=0.
  - FSM goes to IDLE; bit counter, shift register, timeout counter, ext flag and brk flag all clear.
  - Synchronizers and filter preset to 1 (idle bus level).
  - Reset mid-frame discards the partial frame with no pulses.
- Input conditioning:
  - Both pins pass through 2-flop synchronizers.
  - ps2_clk is filtered: the filtered level changes only after FILTER_LEN consecutive equal samples.
  - A fall event is a single cycle where the filtered clock goes 1->0.
  - Data is sampled from the synchronized ps2_data on the fall-event cycle.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on fall with data=0 (start bit), go to DATA with bit count 0. On fall with data=1, stay in IDLE (no error).
  - DATA: on each fall, shift the data bit in LSB-first and increment the count. After the 8th bit, go to PARITY.
  - PARITY: on fall, capture the parity bit and go to STOP.
  - STOP: on fall, check stop bit = 1 and odd parity (data ones + parity bit = odd). Go to IDLE in every case.
- Byte processing, in the cycle after a good STOP:
  - byte=0xE0: set ext; no strobe.
  - byte=0xF0: set brk; no strobe.
  - Otherwise: data_o <= {21'b0, 1'b1, ext, brk, byte}, we_o=1 for exactly one cycle; ext and brk clear.
- Latency: we_o asserts exactly 1 cycle after the fall event that samples the stop bit.
- Errors and timeout:
  - Parity error or stop=0: frame_err_o pulses 1 cycle, no we_o, ext and brk clear, back to IDLE.
  - The timeout counter runs in any state other than IDLE and reloads on every fall event.
  - On reaching TIMEOUT_CYC: frame_err_o pulses, go to IDLE, ext and brk clear.
- data_o holds its last value between strobes. we_o and frame_err_o are never high in the same cycle.
- A fall event that coincides with a timeout is treated as a timeout. The frame is abandoned and the fall is not reinterpreted as a start bit.
- Glitches on ps2_clk shorter than FILTER_LEN cycles produce no fall event.

Test Plan:
- Send frame 0x1C (start 0, data LSB-first, parity 0, stop 1) at a 12.5 kHz PS/2 clock -> one we_o pulse; data_o=0x0000041C; frame_err_o stays 0.
- Send F0 then 1C -> no strobe after F0; after 1C, data_o=0x0000051C. Send E0,75 -> data_o=0x00000675. Send E0,F0,75 -> data_o=0x00000775 with a single we_o pulse.
- Send 0x1C with parity bit 1 -> frame_err_o pulses once, no we_o. Then send a clean 0x29 -> data_o=0x00000429 with no stale brk/ext.
- Send start plus 5 data bits, then hold ps2_clk high for 250 us -> frame_err_o pulse about 200 us after the last fall. A following clean 0x1C decodes correctly.
- Inject 3-cycle low glitches on ps2_clk during idle and mid-frame -> no fall events; the frame still decodes as 0x1C.
- Assert rst=0 for 2 cycles after the 4th data bit -> all outputs 0, no pulses. The next full 0x1C frame gives data_o=0x0000041C.
